// File: rtl/video_pkg.sv
// Shared video constants for the capture and HDMI sides.
// Holds mode geometry, line-buffer FSM states and RAM address width.
package video_pkg;

  localparam int LINE_WIDTH_480   = 720;
  localparam int FRAME_HEIGHT_480P = 480;
  localparam int FRAME_HEIGHT_480I = 240;
  localparam int LINE_WIDTH_VGA   = 640;
  localparam int FRAME_HEIGHT_VGA = 480;

  localparam int SLOT_BITS_DEF = 2;
  localparam int RAM_AW = 10 + SLOT_BITS_DEF;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

endpackage

// File: rtl/line_buffer_writer.sv
// Writes captured pixels into a ring of line slots in the line-buffer RAM.
// Signals line completion and when enough lines are buffered to start output.
module line_buffer_writer
  import video_pkg::*;
#(
  parameter int LINE_WIDTH   = LINE_WIDTH_480,
  parameter int FRAME_HEIGHT = FRAME_HEIGHT_480P,
  parameter int SLOT_BITS    = SLOT_BITS_DEF,
  parameter int FILL_LINES   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [11:0]            counterX,
  input  logic [11:0]            counterY,
  input  logic [7:0]             red,
  input  logic [7:0]             green,
  input  logic [7:0]             blue,
  input  logic                   resync,
  output logic                   wren,
  output logic [10+SLOT_BITS-1:0] wraddress,
  output logic [23:0]            wrdata,
  output logic                   line_done,
  output logic [SLOT_BITS-1:0]   line_slot,
  output logic                   starttrigger
);

  localparam logic [11:0] LW   = 12'(LINE_WIDTH);
  localparam logic [11:0] LAST = 12'(LINE_WIDTH - 1);
  localparam logic [11:0] FH   = 12'(FRAME_HEIGHT);
  localparam logic [11:0] FILL = 12'(FILL_LINES);

  state_t      state;
  logic [11:0] prev_x;
  logic [11:0] line_cnt;
  logic [11:0] cnt_next;
  logic        last_q;
  logic        px_new;
  logic        visible;
  logic        frame_start;
  logic        do_write;

  assign px_new      = counterX != prev_x;
  assign visible     = (counterX < LW) && (counterY < FH);
  assign frame_start = px_new && counterX == 12'd0 && counterY == 12'd0;
  assign cnt_next    = (line_cnt >= FH) ? FH : line_cnt + 12'd1;

  // The qualifying frame start writes its own (0,0) pixel.
  always_comb begin
    do_write = 1'b0;
    unique case (state)
      WAIT_FRAME: do_write = frame_start && !resync;
      ACTIVE:     do_write = px_new && visible && !resync;
      default:    do_write = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= WAIT_FRAME;
      prev_x       <= 12'hFFF;
      line_cnt     <= 12'd0;
      last_q       <= 1'b0;
      wren         <= 1'b0;
      wraddress    <= '0;
      wrdata       <= 24'd0;
      line_done    <= 1'b0;
      line_slot    <= '0;
      starttrigger <= 1'b0;
    end else begin
      prev_x    <= counterX;
      wren      <= 1'b0;
      line_done <= 1'b0;
      last_q    <= 1'b0;
      if (resync) begin
        state        <= WAIT_FRAME;
        starttrigger <= 1'b0;
      end else begin
        if (frame_start) begin
          state    <= ACTIVE;
          line_cnt <= 12'd0;
        end
        if (do_write) begin
          wren      <= 1'b1;
          wraddress <= {counterY[SLOT_BITS-1:0], counterX[9:0]};
          wrdata    <= {red, green, blue};
          last_q    <= counterX == LAST;
        end
        // Slot of the finished line is still held in wraddress.
        if (last_q) begin
          line_done <= 1'b1;
          line_slot <= wraddress[10+SLOT_BITS-1:10];
          if (!frame_start)
            line_cnt <= cnt_next;
          if (cnt_next >= FILL)
            starttrigger <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_writer.sv
// Directed bench for line_buffer_writer on a reduced 8x8 visible geometry.
// Each pixel is held for two clocks; a small reference model tracks state.
module tb_line_buffer_writer;

  localparam int LW   = 8;
  localparam int FH   = 8;
  localparam int SB   = 2;
  localparam int FILL = 2;
  localparam int HT   = 12;
  localparam int VT   = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic [11:0]   counterX;
  logic [11:0]   counterY;
  logic [7:0]    red, green, blue;
  logic          resync;
  logic          wren;
  logic [11:0]   wraddress;
  logic [23:0]   wrdata;
  logic          line_done;
  logic [SB-1:0] line_slot;
  logic          starttrigger;

  int n_tests = 0;
  int n_fail  = 0;
  int wcnt    = 0;
  int lcnt    = 0;

  bit m_act  = 1'b0;
  bit m_trig = 1'b0;
  int m_cnt  = 0;

  line_buffer_writer #(
    .LINE_WIDTH(LW), .FRAME_HEIGHT(FH),
    .SLOT_BITS(SB), .FILL_LINES(FILL)
  ) dut (
    .clock(clock), .reset(reset),
    .counterX(counterX), .counterY(counterY),
    .red(red), .green(green), .blue(blue),
    .resync(resync), .wren(wren),
    .wraddress(wraddress), .wrdata(wrdata),
    .line_done(line_done), .line_slot(line_slot),
    .starttrigger(starttrigger)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wren) wcnt <= wcnt + 1;
    if (line_done) lcnt <= lcnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [23:0] col(input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    if (x == LW - 1 && y == 3) return 24'h123456;
    return {xb, yb, 8'hA5 ^ xb ^ yb};
  endfunction

  task automatic px(input int x, input int y,
                    input bit rs, input bit rst);
    bit vis, wr, ld;
    counterX = 12'(x);
    counterY = 12'(y);
    {red, green, blue} = col(x, y);
    resync = rs;
    reset  = rst;
    vis = (x < LW) && (y < FH);
    wr  = 1'b0;
    if (rst) begin
      m_act = 0; m_trig = 0; m_cnt = 0;
    end else begin
      if (rs) begin
        m_act = 0; m_trig = 0;
      end else if (x == 0 && y == 0) begin
        m_act = 1; m_cnt = 0;
      end
      wr = m_act && vis && !rs;
    end
    step();
    if (rst) begin
      check("rst_wren", 32'(wren), 0);
      check("rst_addr", 32'(wraddress), 0);
      check("rst_data", 32'(wrdata), 0);
      check("rst_ldone", 32'(line_done), 0);
      check("rst_slot", 32'(line_slot), 0);
      check("rst_trig", 32'(starttrigger), 0);
    end else begin
      check("wren", 32'(wren), 32'(wr));
      if (wr) begin
        check("addr", 32'(wraddress), 32'((y % 4) * 1024 + x));
        check("data", 32'(wrdata), 32'(col(x, y)));
      end
      if (wr && x == 5 && y == 6)
        check("addr_5_6", 32'(wraddress), 32'h805);
      if (wr && x == LW - 1 && y == 3)
        check("data_last_3", 32'(wrdata), 32'h123456);
      check("trig_a", 32'(starttrigger), 32'(m_trig));
    end
    reset = 1'b0;
    ld = wr && (x == LW - 1);
    if (ld) begin
      m_cnt = (m_cnt >= FH) ? FH : m_cnt + 1;
      if (m_cnt >= FILL) m_trig = 1;
    end
    step();
    check("wren_hold", 32'(wren), 0);
    check("ldone", 32'(line_done), 32'(ld));
    if (ld) check("slot", 32'(line_slot), 32'(y % 4));
    check("trig_b", 32'(starttrigger), 32'(m_trig));
  endtask

  task automatic frame(input int rs_x, input int rs_y,
                       input int rst_x, input int rst_y);
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++)
        px(x, y, (x == rs_x && y == rs_y),
           (x == rst_x && y == rst_y));
    resync = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    resync = 1'b0;
    counterX = 12'(HT - 1);
    counterY = 12'(VT - 1);
    {red, green, blue} = 24'd0;
    repeat (3) step();
    check("init_wren", 32'(wren), 0);
    check("init_addr", 32'(wraddress), 0);
    check("init_data", 32'(wrdata), 0);
    check("init_ldone", 32'(line_done), 0);
    check("init_slot", 32'(line_slot), 0);
    check("init_trig", 32'(starttrigger), 0);
    reset = 1'b0;
    step();
    check("idle_wren", 32'(wren), 0);

    for (int f = 0; f < 2; f++) begin
      wcnt = 0; lcnt = 0;
      frame(-1, -1, -1, -1);
      check("frame_wren_cnt", 32'(wcnt), 32'(LW * FH));
      check("frame_ldone_cnt", 32'(lcnt), 32'(FH));
    end

    frame(5, 3, -1, -1);
    frame(-1, -1, -1, -1);
    frame(-1, -1, 3, 2);
    frame(0, 0, -1, -1);

    wcnt = 0; lcnt = 0;
    frame(-1, -1, -1, -1);
    check("final_wren_cnt", 32'(wcnt), 32'(LW * FH));
    check("final_ldone_cnt", 32'(lcnt), 32'(FH));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
